dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have the following parameters, one per line (name, default, meaning):
  DEPTH_WORDS, 256, number of 32-bit words stored.
  LATENCY, 2, wait cycles inserted between request acceptance and response (legal 0..15).
REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
  clk, in, 1, single clock; all state changes on rising edge.
  reset, in, 1, asynchronous, active-low reset.
  req_valid, in, 1, processor presents a load/store request.
  req_ready, out, 1, responder can accept a request.
  req_we, in, 1, 1 = store, 0 = load.
  req_addr, in, 32, byte address.
  req_f3, in, 3, RISC-V funct3 access size/sign.
  req_wdata, in, 32, store data, right-aligned.
  resp_valid, out, 1, response available.
  resp_ready, in, 1, processor accepts the response.
  resp_rdata, out, 32, load result, extended per f3; 0 for stores and errors.
  resp_err, out, 1, request was misaligned, out of range or had an illegal f3.
  busy, out, 1, high in any state other than IDLE.
REQ-003 Clock and reset SHALL be one clock; reset is asynchronous and active-low.

Function
REQ-004 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-005 In IDLE, req_ready SHALL be 1; in WAIT and RESP it SHALL be 0.
REQ-006 A request SHALL be accepted on an edge where req_valid and req_ready are both 1; at that edge addr, we, f3 and wdata SHALL be captured.
REQ-007 On acceptance, the FSM SHALL go to WAIT with the counter loaded to LATENCY. If LATENCY = 0, it SHALL go directly to RESP.
REQ-008 In WAIT, the counter SHALL decrement each cycle. The FSM SHALL go to RESP on the edge where the counter is 1.
REQ-009 resp_valid SHALL first be high exactly LATENCY+1 cycles after the acceptance edge.
REQ-010 In RESP, resp_valid SHALL be 1, and resp_rdata and resp_err SHALL be held stable until resp_ready = 1. On that edge the FSM SHALL return to IDLE.
REQ-011 There SHALL be no back-to-back bypass: at least one IDLE cycle occurs between responses.
REQ-012 Legal load f3 SHALL be 000 (lb), 001 (lh), 010 (lw), 100 (lbu) and 101 (lhu). Legal store f3 SHALL be 000 (sb), 001 (sh) and 010 (sw). Any other f3 SHALL set resp_err.
REQ-013 A request SHALL be treated as misaligned, and set resp_err, when:
  - it is a halfword access with addr[0] = 1, or
  - it is a word access with addr[1:0] != 00.
REQ-014 A request with addr[31:2] >= DEPTH_WORDS SHALL set resp_err.
REQ-015 On an error: no memory write SHALL occur, and resp_rdata SHALL be 0.
REQ-016 A legal store SHALL be committed on the edge entering RESP, using byte enables derived from addr[1:0] and f3. wdata[7:0] or wdata[15:0] SHALL be replicated into the selected lanes.
REQ-017 A legal load SHALL read the word at addr[31:2] on the edge entering RESP, select the byte or halfword at addr[1:0], and sign- or zero-extend it per f3 to 32 bits.
REQ-018 A load SHALL observe all stores committed before it, with no stale read.
REQ-019 Inputs on req_* SHALL be ignored while req_ready = 0.
REQ-020 resp_ready while resp_valid = 0 SHALL have no effect.

Reset
REQ-021 While reset = 0, outputs SHALL be: state IDLE, counter 0, req_ready 1 (once released), resp_valid 0, resp_rdata 0, resp_err 0, busy 0.
REQ-022 Reset asserted during WAIT SHALL abort the request; an uncommitted store SHALL NOT be written.
REQ-023 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-024 Package dmem_pkg SHALL hold the f3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU), the state enum and the LATENCY legal-range constant.
REQ-025 Storage SHALL be a single sub-module, dmem_array: DEPTH_WORDS x 32 bits, synchronous write with a 4-bit byte enable, and read performed in the same edge as the write.

Verification
REQ-026 The bench SHALL cover the following scenarios:
  - sw 0xDEADBEEF @0x10, then lw @0x10, LATENCY=2 -> resp_valid 3 cycles after each acceptance; rdata 0xDEADBEEF, err 0.
  - sb 0x80 @0x13, then lb @0x13 and lbu @0x13 -> 0xFFFFFF80 and 0x00000080; the other bytes of word 0x10 are unchanged.
  - lw @0x12 and sh @0x21 -> resp_err 1, rdata 0, memory unchanged on readback.
  - lw @0x400 with DEPTH_WORDS=256 -> resp_err 1. Load with f3=011 -> resp_err 1.
  - resp_ready held 0 for 5 cycles in RESP -> resp_valid, rdata and err stable; req_ready 0 throughout. LATENCY=0 -> resp_valid on the cycle after acceptance.
  - reset pulsed low mid-WAIT of sw 0x12345678 @0x20 -> outputs at reset values immediately; a subsequent lw @0x20 returns the prior contents.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and access helpers for the data-memory responder.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned LATENCY_MIN = 0;
  localparam int unsigned LATENCY_MAX = 15;
  localparam int unsigned CNT_W       = $clog2(LATENCY_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return f3 inside {F3_B, F3_H, F3_W};
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: return off[0];
      F3_W:        return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B:    return 4'b0001 << off;
      F3_H:    return off[1] ? 4'b1100 : 4'b0011;
      F3_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Narrow store data is replicated so every enabled lane sees the right bytes.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wdata);
    case (f3)
      F3_B:    return {4{wdata[7:0]}};
      F3_H:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {off, 3'b000});
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    return {{24{b[7]}}, b};
      F3_BU:   return {24'h0, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_HU:   return {16'h0, h};
      F3_W:    return word;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with byte-enabled synchronous write; the read is taken on the
// same enabled edge (old contents), and the array is never cleared.
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      rdata_q <= mem_q[addr];
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with a programmable wait before each response.
//
//   state   | meaning
//   IDLE    | ready for a request
//   WAIT    | request captured, counting down the inserted latency
//   RESP    | response presented, held until the processor takes it
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_f3,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // Out-of-range latencies saturate so the counter never wraps.
  localparam int unsigned LAT_EFF = (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
  localparam bit          LAT_ZERO = (LAT_EFF == 0);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      addr_q;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [31:0]      wdata_q;
  logic             req_ready_q;
  logic             resp_valid_q;
  logic             resp_err_q;
  logic             busy_q;

  logic        accept;
  logic        go_resp;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [2:0]  acc_f3;
  logic [31:0] acc_wdata;
  logic        acc_err;
  logic        arr_en;
  logic [31:0] arr_rdata;

  assign accept  = req_valid & req_ready_q;
  assign go_resp = (accept & LAT_ZERO) |
                   ((state_q == ST_WAIT) & (cnt_q == CNT_W'(1)));

  // With zero latency the access happens on the acceptance edge, before capture.
  assign acc_we    = (state_q == ST_IDLE) ? req_we    : we_q;
  assign acc_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
  assign acc_f3    = (state_q == ST_IDLE) ? req_f3    : f3_q;
  assign acc_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;

  assign acc_err = ~f3_legal(acc_we, acc_f3) |
                   misaligned(acc_f3, acc_addr[1:0]) |
                   ({2'b00, acc_addr[31:2]} >= DEPTH_WORDS);

  // Gating with reset keeps the array untouched while reset is held low.
  assign arr_en = go_resp & ~acc_err & reset;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .en   (arr_en),
    .we   (acc_we),
    .be   (byte_en(acc_f3, acc_addr[1:0])),
    .addr (acc_addr[AW+1:2]),
    .wdata(store_lanes(acc_f3, acc_wdata)),
    .rdata(arr_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      f3_q         <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            addr_q      <= req_addr;
            we_q        <= req_we;
            f3_q        <= req_f3;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (go_resp) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= acc_err;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= CNT_W'(LAT_EFF);
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (go_resp) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= acc_err;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign busy       = busy_q;
  // Array output only moves on access edges, so this stays stable throughout RESP.
  assign resp_rdata = (resp_valid_q & ~resp_err_q & ~we_q) ?
                      load_extend(f3_q, addr_q[1:0], arr_rdata) : 32'h0;

endmodule
